uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit-side consumer of the 8-byte TX FIFO in the APB-UART path. Pops one byte at a time using the FIFO's empty/readEn/dataOut interface and serializes it onto the UART line. Frame is 8N1: start bit, 8 data bits LSB first, one stop bit, with an optional parity bit. Bit timing comes from an internal clock divider, so no external baud tick is needed.

Parameters:
- BAUD_DIV, 868: clk cycles per UART bit (100 MHz / 115200). Legal range is BAUD_DIV >= 2.
- PARITY_ODD, 0: parity sense, 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO Empty flag
- fifo_data  in  8  FIFO dataOut; valid the cycle after fifo_rd_en was high
- fifo_rd_en  out  1  FIFO readEn; one-cycle pulse per byte
- tx  out  1  serial line, idle high
- busy  out  1  high whenever the state is not IDLE
- tx_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset state, applied at the clk edge while reset=1:
  - tx=1, fifo_rd_en=0, busy=0, tx_done=0
  - state=IDLE, baud counter=0, bit index=0, shift register=0
- All outputs are registered.
- States: IDLE, READ, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0 is sampled, go to READ with fifo_rd_en=1 for that one cycle.
- READ:
  - fifo_rd_en returns to 0 at the next edge.
  - Go to LOAD; the FIFO updates dataOut on this same edge.
- LOAD:
  - fifo_data is captured into the shift register.
  - tx=0, baud counter=0, go to START.
- Later changes on fifo_data or fifo_empty have no effect on the frame in progress.
- Bit timing:
  - Every bit state lasts exactly BAUD_DIV cycles.
  - Baud counter is $clog2(BAUD_DIV) bits wide and counts 0..BAUD_DIV-1; it wraps to 0 at a bit boundary.
- START -> DATA:
  - tx=shreg[0], bit index=0.
- DATA:
  - At each bit boundary, shift right and increment the bit index.
  - After bit index 7 completes, go to STOP (or PARITY when enabled); tx=1 in STOP.
- STOP:
  - After BAUD_DIV cycles, go to IDLE with tx_done=1 for exactly one cycle.
- Latency:
  - fifo_rd_en rises the cycle after fifo_empty=0 is first sampled in IDLE.
  - tx falls 2 cycles after fifo_rd_en rises.
- Back-to-back frames:
  - The STOP -> IDLE -> READ -> LOAD path adds a fixed 3 cycles of idle-high line after each stop bit.
  - Frame period is 10*BAUD_DIV+3 cycles (11*BAUD_DIV+3 with parity).
- Exactly one fifo_rd_en pulse per transmitted byte.
- No read is ever issued while fifo_empty=1, or while the state is not IDLE.
- Reset mid-frame:
  - tx=1 and busy=0 at the next edge.
  - The partial byte is discarded; no tx_done; no extra fifo_rd_en.
- tx_done and fifo_rd_en are never high in the same cycle.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP and lasts BAUD_DIV cycles.
  - tx = ^byte XOR PARITY_ODD.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state, 10-bit frame.
  - PARITY_ODD is ignored.

Test Plan (BAUD_DIV=4):
1. Reset, then hold fifo_empty=1 for 100 cycles -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
2. One byte 0xA5 in FIFO -> exactly one fifo_rd_en pulse; tx=0 two cycles later; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses once 40 cycles after tx fell; then busy=0.
3. Three bytes 0x00,0xFF,0x55 queued -> 3 fifo_rd_en pulses; frames on tx match the LSB-first data; 3 idle-high cycles between each stop bit and the next start bit; 3 tx_done pulses 43 cycles apart.
4. reset asserted during data bit 3 of 0xA5 -> tx=1 and busy=0 at the next edge; no tx_done; no further fifo_rd_en until fifo_empty=0 is seen in IDLE.
5. UART_TX_PARITY_EN, PARITY_ODD=0 -> byte 0xA5 gives parity bit 0, byte 0x07 gives parity bit 1; each frame is 44 cycles; tx_done after the stop bit.
6. fifo_empty falls and rises again while a frame is mid-transmission -> no fifo_rd_en until the state is IDLE; the transmitted byte is unchanged.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter that drains a byte FIFO through its empty/readEn/dataOut handshake.
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
    parameter int BAUD_DIV   = 868,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             rd_en_q, rd_en_d;
    logic             done_q, done_d;
    logic             bit_end;
    logic [CNT_W-1:0] cnt_next;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`else
    // Parity sense has no role when no parity bit is sent.
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    assign bit_end  = (cnt_q == CNT_MAX);
    assign cnt_next = bit_end ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_READ;
                    rd_en_d = 1'b1;
                end
            end
            // FIFO presents the popped byte on dataOut at the edge leaving READ.
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = fifo_data;
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_START;
`ifdef UART_TX_PARITY_EN
                par_d   = (^fifo_data) ^ PARITY_ODD;
`endif
            end
            S_START: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at BAUD_DIV=4 with a behavioural FIFO and a frame scoreboard.
module tb_uart_tx_serializer;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en, tx, busy, tx_done;

    always #5 clk = ~clk;

    uart_tx_serializer #(.BAUD_DIV(B), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Behavioural FIFO: write port driven by the stimulus, read port by the DUT.
    logic [7:0] fifo_mem[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] model_data = 8'h00;
    logic       model_empty = 1'b1;
    int         underflow = 0;
    logic       fake_avail = 1'b0;
    logic [7:0] glitch = 8'h00;

    assign fifo_empty = model_empty & ~fake_avail;
    assign fifo_data  = model_data ^ glitch;

    always @(posedge clk) begin
        if (wr_en) fifo_mem.push_back(wr_data);
        if (fifo_rd_en) begin
            if (fifo_mem.size() > 0) model_data <= fifo_mem.pop_front();
            else underflow <= underflow + 1;
        end
        model_empty <= (fifo_mem.size() == 0);
    end

    // Protocol monitor.
    int   cyc = 0;
    int   rd_cnt = 0, done_cnt = 0, viol = 0, last_rd_cyc = 0;
    logic prev_empty = 1'b1, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (prev_empty === 1'b1 || prev_busy === 1'b1) viol <= viol + 1;
        end
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_done === 1'b1 && fifo_rd_en === 1'b1) viol <= viol + 1;
        prev_empty <= fifo_empty;
        prev_busy  <= busy;
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;   // line bits in transmit order, leftmost first
        logic       par;   // even parity bit
    } vec_t;

    vec_t vecs[6];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int n);
        logic [7:0] bs[3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = bs[k];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, output int fall_cyc);
        vec_t e;
        int   w;
        logic b;
        logic ok;
        fall_cyc = -1;
        check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        w = 0;
        while (tx !== 1'b0 && w < 20 * B) begin
            @(negedge clk);
            w++;
        end
        check({tag, " start_seen"}, 32'(tx), 32'd0);
        if (tx !== 1'b0) return;
        fall_cyc = cyc;
        check({tag, " rd_to_tx"}, 32'(cyc - last_rd_cyc), 32'd2);
        ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (PAR && i == 9) b = e.par;
            else if (i >= 9)   b = 1'b1;
            else               b = e.seq[9 - i];
            for (int c = 0; c < B; c++) begin
                if (tx !== b || tx_done !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
        end
        check({tag, " bits"}, 32'(ok), 32'd1);
        check({tag, " done_pulse"}, 32'(tx_done), 32'd1);
        check({tag, " idle_line"}, 32'(tx), 32'd1);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done_single"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   f0, f1, f2, rd0, d0, w;
        logic ok;

        vecs[0] = '{data: 8'hA5, seq: 10'b0101001011, par: 1'b0};
        vecs[1] = '{data: 8'h07, seq: 10'b0111000001, par: 1'b1};
        vecs[2] = '{data: 8'h00, seq: 10'b0000000001, par: 1'b0};
        vecs[3] = '{data: 8'hFF, seq: 10'b0111111111, par: 1'b0};
        vecs[4] = '{data: 8'h55, seq: 10'b0101010101, par: 1'b0};
        vecs[5] = '{data: 8'h80, seq: 10'b0000000011, par: 1'b1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset done", 32'(tx_done), 32'd0);
        reset = 1'b0;

        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
        end
        check("idle_hold", 32'(ok), 32'd1);

        // Single-byte frames from the table.
        for (int i = 0; i < 6; i++) begin
            rd0 = rd_cnt;
            d0  = done_cnt;
            sb.push_back(vecs[i]);
            push_bytes(vecs[i].data, 8'h00, 8'h00, 1);
            check_frame($sformatf("vec%0d", i), f0);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d rd_pulses", i), 32'(rd_cnt - rd0), 32'd1);
            check($sformatf("vec%0d done_pulses", i), 32'(done_cnt - d0), 32'd1);
        end

        // Back-to-back frames.
        rd0 = rd_cnt;
        d0  = done_cnt;
        sb.push_back(vecs[2]);
        sb.push_back(vecs[3]);
        sb.push_back(vecs[4]);
        push_bytes(8'h00, 8'hFF, 8'h55, 3);
        check_frame("b2b0", f0);
        check_frame("b2b1", f1);
        check_frame("b2b2", f2);
        check("b2b period01", 32'(f1 - f0), 32'(NB * B + 3));
        check("b2b period12", 32'(f2 - f1), 32'(NB * B + 3));
        repeat (3) @(negedge clk);
        check("b2b rd_pulses", 32'(rd_cnt - rd0), 32'd3);
        check("b2b done_pulses", 32'(done_cnt - d0), 32'd3);

        // Reset during data bit 3 of 0xA5.
        push_bytes(8'hA5, 8'h00, 8'h00, 1);
        w = 0;
        while (tx !== 1'b0 && w < 20 * B) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid start_seen", 32'(tx), 32'd0);
        repeat (B + 3 * B + 1) @(negedge clk);
        check("rst_mid bit3", 32'(tx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid tx", 32'(tx), 32'd1);
        check("rst_mid busy", 32'(busy), 32'd0);
        reset = 1'b0;
        rd0 = rd_cnt;
        d0  = done_cnt;
        repeat (60) @(negedge clk);
        check("rst_mid no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("rst_mid line_idle", 32'(tx), 32'd1);
        sb.push_back(vecs[0]);
        push_bytes(8'hA5, 8'h00, 8'h00, 1);
        check_frame("rst_resume", f0);
        check("rst_resume rd_pulses", 32'(rd_cnt - rd0), 32'd1);

        // FIFO flags and data wiggle while a frame is in flight.
        rd0 = rd_cnt;
        sb.push_back(vecs[0]);
        push_bytes(8'hA5, 8'h00, 8'h00, 1);
        fork
            check_frame("wiggle", f0);
            begin
                repeat (12) @(negedge clk);
                fake_avail = 1'b1;
                glitch     = 8'hFF;
                repeat (2 * B) @(negedge clk);
                fake_avail = 1'b0;
                repeat (B) @(negedge clk);
                glitch     = 8'h00;
            end
        join
        repeat (3) @(negedge clk);
        check("wiggle rd_pulses", 32'(rd_cnt - rd0), 32'd1);

        check("protocol_violations", 32'(viol), 32'd0);
        check("fifo_underflow", 32'(underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
